// File: rtl/mlp_axis_pkg.sv
// Shared helpers for the MLP AXI4-Stream input stage: ceil-log2 and derived widths.
// Purely compile-time; no logic, no latency, no flow control.
package mlp_axis_pkg;

    localparam int C_DEF_TDATA_WIDTH = 32;
    localparam int C_DEF_FIFO_DEPTH  = 16;

    function automatic int clog2(input int value);
        int r;
        r = 0;
        while ((1 << r) < value) r++;
        return r;
    endfunction

    function automatic int strb_width(input int data_width);
        return data_width / 8;
    endfunction

    // One extra bit beyond the index separates full from empty when indices match.
    function automatic int ptr_width(input int depth);
        return clog2(depth) + 1;
    endfunction

    localparam int C_DEF_STRB_WIDTH = strb_width(C_DEF_TDATA_WIDTH);
    localparam int C_DEF_PTR_WIDTH  = ptr_width(C_DEF_FIFO_DEPTH);

endpackage

// File: rtl/mlp_sync_fifo.sv
// Generic first-word-fall-through register FIFO with level; write-to-valid latency 1 cycle.
// Writes when full and reads when empty are dropped; flush clears pointers and level next edge.
module mlp_sync_fifo
    import mlp_axis_pkg::*;
#(
    parameter int WIDTH = 33,
    parameter int DEPTH = 16
) (
    input  logic                       clk,
    input  logic                       rst,
    input  logic                       flush,
    input  logic                       wr_en,
    input  logic [WIDTH-1:0]           wr_dat,
    input  logic                       rd_en,
    output logic [WIDTH-1:0]           rd_dat,
    output logic                       rd_vld,
    output logic [ptr_width(DEPTH)-1:0] level,
    output logic [ptr_width(DEPTH)-1:0] level_nxt
);

    localparam int IDX_W = clog2(DEPTH);
    localparam int PTR_W = IDX_W + 1;

    logic [WIDTH-1:0] mem [DEPTH];
    logic [PTR_W-1:0] wr_ptr;
    logic [PTR_W-1:0] rd_ptr;
    logic [PTR_W-1:0] level_q;
    logic             vld_q;
    logic             full;
    logic             empty;
    logic             wr_ok;
    logic             rd_ok;

    assign full  = (wr_ptr[IDX_W] != rd_ptr[IDX_W]) &&
                   (wr_ptr[IDX_W-1:0] == rd_ptr[IDX_W-1:0]);
    assign empty = (wr_ptr == rd_ptr);
    assign wr_ok = wr_en && !full && !flush;
    assign rd_ok = rd_en && !empty && !flush;

    always_comb begin
        level_nxt = level_q;
        if (flush) begin
            level_nxt = '0;
        end else begin
            case ({wr_ok, rd_ok})
                2'b10:   level_nxt = level_q + PTR_W'(1);
                2'b01:   level_nxt = level_q - PTR_W'(1);
                default: level_nxt = level_q;
            endcase
        end
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            wr_ptr  <= '0;
            rd_ptr  <= '0;
            level_q <= '0;
            vld_q   <= 1'b0;
            for (int i = 0; i < DEPTH; i++) mem[i] <= '0;
        end else begin
            level_q <= level_nxt;
            vld_q   <= (level_nxt != '0);
            if (flush) begin
                wr_ptr <= '0;
                rd_ptr <= '0;
            end else begin
                if (wr_ok) begin
                    mem[wr_ptr[IDX_W-1:0]] <= wr_dat;
                    wr_ptr <= wr_ptr + PTR_W'(1);
                end
                if (rd_ok) rd_ptr <= rd_ptr + PTR_W'(1);
            end
        end
    end

    assign rd_dat = mem[rd_ptr[IDX_W-1:0]];
    assign rd_vld = vld_q;
    assign level  = level_q;

endmodule

// File: rtl/mlp_axis_slave_fifo.sv
// AXIS slave input stage: strobe-masked, TLAST-tagged FWFT buffer with level/frame status; 1-cycle latency.
// TREADY is registered and drops when the FIFO is full or during a flush cycle.
module mlp_axis_slave_fifo
    import mlp_axis_pkg::*;
#(
    parameter int C_S_AXIS_TDATA_WIDTH = 32,
    parameter int C_FIFO_DEPTH         = 16,
    parameter int C_STRB_MASK_EN       = 1,
    parameter int C_FRAME_CNT_WIDTH    = 8
) (
    input  logic                                  S_AXIS_ACLK,
    input  logic                                  S_AXIS_ARESET,
    input  logic                                  S_AXIS_TVALID,
    output logic                                  S_AXIS_TREADY,
    input  logic [C_S_AXIS_TDATA_WIDTH-1:0]       S_AXIS_TDATA,
    input  logic [C_S_AXIS_TDATA_WIDTH/8-1:0]     S_AXIS_TSTRB,
    input  logic                                  S_AXIS_TLAST,
    input  logic                                  pi_data_read,
    input  logic                                  pi_flush,
    output logic [C_S_AXIS_TDATA_WIDTH-1:0]       po_mlp_data,
    output logic                                  po_mlp_data_valid,
    output logic                                  po_mlp_data_last,
    output logic [ptr_width(C_FIFO_DEPTH)-1:0]    po_fifo_level,
    output logic [C_FRAME_CNT_WIDTH-1:0]          po_frame_count,
    output logic                                  po_frame_ready
);

    localparam int DW    = C_S_AXIS_TDATA_WIDTH;
    localparam int STRBW = strb_width(DW);
    localparam int LVL_W = ptr_width(C_FIFO_DEPTH);

    logic [DW-1:0]                masked_dat;
    logic [DW:0]                  head_dat;
    logic                         head_vld;
    logic [LVL_W-1:0]             level_nxt;
    logic                         tready_q;
    logic                         wr_en;
    logic                         rd_en;
    logic                         frm_inc;
    logic                         frm_dec;
    logic [C_FRAME_CNT_WIDTH-1:0] frame_q;
    logic [C_FRAME_CNT_WIDTH-1:0] frame_nxt;

    always_comb begin
        masked_dat = S_AXIS_TDATA;
        if (C_STRB_MASK_EN != 0) begin
            for (int b = 0; b < STRBW; b++) begin
                if (!S_AXIS_TSTRB[b]) masked_dat[b*8 +: 8] = 8'h00;
            end
        end
    end

    assign wr_en = S_AXIS_TVALID && tready_q;
    assign rd_en = pi_data_read && head_vld;

    mlp_sync_fifo #(
        .WIDTH (DW + 1),
        .DEPTH (C_FIFO_DEPTH)
    ) u_fifo (
        .clk       (S_AXIS_ACLK),
        .rst       (S_AXIS_ARESET),
        .flush     (pi_flush),
        .wr_en     (wr_en),
        .wr_dat    ({S_AXIS_TLAST, masked_dat}),
        .rd_en     (rd_en),
        .rd_dat    (head_dat),
        .rd_vld    (head_vld),
        .level     (po_fifo_level),
        .level_nxt (level_nxt)
    );

    assign frm_inc = wr_en && S_AXIS_TLAST && !pi_flush;
    assign frm_dec = rd_en && head_dat[DW] && !pi_flush;

    // Increment saturates at all-ones; decrement clamps at zero.
    always_comb begin
        frame_nxt = frame_q;
        if (pi_flush) begin
            frame_nxt = '0;
        end else if (frm_inc && !frm_dec) begin
            if (frame_q != '1) frame_nxt = frame_q + C_FRAME_CNT_WIDTH'(1);
        end else if (frm_dec && !frm_inc) begin
            if (frame_q != '0) frame_nxt = frame_q - C_FRAME_CNT_WIDTH'(1);
        end
    end

    always_ff @(posedge S_AXIS_ACLK or posedge S_AXIS_ARESET) begin
        if (S_AXIS_ARESET) begin
            tready_q <= 1'b0;
            frame_q  <= '0;
        end else begin
            tready_q <= (level_nxt < LVL_W'(C_FIFO_DEPTH)) && !pi_flush;
            frame_q  <= frame_nxt;
        end
    end

    assign S_AXIS_TREADY     = tready_q;
    assign po_mlp_data       = head_dat[DW-1:0];
    assign po_mlp_data_last  = head_dat[DW];
    assign po_mlp_data_valid = head_vld;
    assign po_frame_count    = frame_q;
    assign po_frame_ready    = (frame_q != '0);

endmodule

// File: tb/tb_mlp_axis_slave_fifo.sv
// Bench for mlp_axis_slave_fifo: directed and random steps against a queue-based reference model.
module tb_mlp_axis_slave_fifo;

    localparam int DEPTH = 16;

    logic        clk = 1'b0;
    logic        rst;
    logic        tvalid;
    logic [31:0] tdata;
    logic [3:0]  tstrb;
    logic        tlast;
    logic        rd;
    logic        fl;

    logic        tready,  tready_nm;
    logic [31:0] dat,     dat_nm;
    logic        vld,     vld_nm;
    logic        last,    last_nm;
    logic [4:0]  lvl,     lvl_nm;
    logic [7:0]  fcnt,    fcnt_nm;
    logic        frdy,    frdy_nm;

    int checks = 0;
    int passes = 0;

    typedef struct {
        logic [31:0] masked;
        logic [31:0] raw;
        logic        l;
    } ent_t;
    ent_t q[$];
    bit   m_rdy;

    always #5 clk = ~clk;

    mlp_axis_slave_fifo dut (
        .S_AXIS_ACLK(clk), .S_AXIS_ARESET(rst), .S_AXIS_TVALID(tvalid), .S_AXIS_TREADY(tready),
        .S_AXIS_TDATA(tdata), .S_AXIS_TSTRB(tstrb), .S_AXIS_TLAST(tlast),
        .pi_data_read(rd), .pi_flush(fl), .po_mlp_data(dat), .po_mlp_data_valid(vld),
        .po_mlp_data_last(last), .po_fifo_level(lvl), .po_frame_count(fcnt), .po_frame_ready(frdy)
    );

    mlp_axis_slave_fifo #(.C_STRB_MASK_EN(0)) dut_nm (
        .S_AXIS_ACLK(clk), .S_AXIS_ARESET(rst), .S_AXIS_TVALID(tvalid), .S_AXIS_TREADY(tready_nm),
        .S_AXIS_TDATA(tdata), .S_AXIS_TSTRB(tstrb), .S_AXIS_TLAST(tlast),
        .pi_data_read(rd), .pi_flush(fl), .po_mlp_data(dat_nm), .po_mlp_data_valid(vld_nm),
        .po_mlp_data_last(last_nm), .po_fifo_level(lvl_nm), .po_frame_count(fcnt_nm),
        .po_frame_ready(frdy_nm)
    );

    function automatic logic [31:0] mask(input logic [31:0] d, input logic [3:0] s);
        logic [31:0] r;
        r = 32'h0;
        for (int b = 0; b < 4; b++) if (s[b]) r = r | (d & (32'hFF << (8 * b)));
        return r;
    endfunction

    task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        checks++;
        assert (obs === exp) passes++;
        else $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
    endtask

    function automatic int frames_held();
        int n = 0;
        foreach (q[i]) if (q[i].l) n++;
        return (n > 255) ? 255 : n;
    endfunction

    task automatic check_state(input string tag);
        chk({tag, " level"},  32'(lvl),   32'(q.size()));
        chk({tag, " valid"},  32'(vld),   32'(q.size() != 0));
        chk({tag, " tready"}, 32'(tready), 32'(m_rdy));
        chk({tag, " frames"}, 32'(fcnt),  32'(frames_held()));
        chk({tag, " frdy"},   32'(frdy),  32'(frames_held() != 0));
        chk({tag, " nm_lvl"}, 32'(lvl_nm), 32'(q.size()));
        if (q.size() != 0) begin
            chk({tag, " data"},    dat,         q[0].masked);
            chk({tag, " last"},    32'(last),   32'(q[0].l));
            chk({tag, " rawdata"}, dat_nm,      q[0].raw);
        end
    endtask

    // One clock: drive inputs, advance the model by the stream rules, compare.
    task automatic step(input logic v, input logic [31:0] d, input logic [3:0] s,
                        input logic l, input logic r, input logic f, input string tag);
        bit   acc, pop;
        ent_t e;
        @(negedge clk);
        tvalid = v; tdata = d; tstrb = s; tlast = l; rd = r; fl = f;
        acc = v && m_rdy && !f;
        pop = r && (q.size() != 0) && !f;
        @(posedge clk);
        #1;
        if (f) q.delete();
        else begin
            if (pop) void'(q.pop_front());
            if (acc) begin
                e.masked = mask(d, s); e.raw = d; e.l = l;
                q.push_back(e);
            end
        end
        m_rdy = !f && (q.size() < DEPTH);
        check_state(tag);
    endtask

    task automatic check_zero(input string tag);
        chk({tag, " tready"}, 32'(tready), 32'h0);
        chk({tag, " valid"},  32'(vld),    32'h0);
        chk({tag, " last"},   32'(last),   32'h0);
        chk({tag, " data"},   dat,         32'h0);
        chk({tag, " level"},  32'(lvl),    32'h0);
        chk({tag, " frames"}, 32'(fcnt),   32'h0);
        chk({tag, " frdy"},   32'(frdy),   32'h0);
    endtask

    initial begin
        rst = 1'b1; tvalid = 0; tdata = 0; tstrb = 4'hF; tlast = 0; rd = 0; fl = 0;
        m_rdy = 0;
        repeat (2) @(negedge clk);
        check_zero("reset");
        rst = 1'b0;
        step(0, 0, 4'hF, 0, 0, 0, "first_edge");

        // Three beats, frame closed on the third.
        step(1, 32'h03, 4'hF, 0, 0, 0, "beat0");
        chk("beat0 head", dat, 32'h00000003);
        step(1, 32'h0E, 4'hF, 0, 0, 0, "beat1");
        step(1, 32'h19, 4'hF, 1, 0, 0, "beat2");
        chk("three level", 32'(lvl), 32'd3);
        chk("three frames", 32'(fcnt), 32'd1);
        repeat (3) step(0, 0, 4'hF, 0, 1, 0, "drain3");

        // Fill to full, hold a 17th beat, then free one slot.
        for (int i = 0; i < DEPTH; i++) step(1, 32'h100 + i, 4'hF, 0, 0, 0, "fill");
        chk("full tready", 32'(tready), 32'h0);
        step(1, 32'hBEEF, 4'hF, 0, 0, 0, "held");
        step(1, 32'hBEEF, 4'hF, 0, 1, 0, "free_slot");
        chk("after pop level", 32'(lvl), 32'd15);
        step(1, 32'hBEEF, 4'hF, 0, 0, 0, "held_accept");
        chk("held accepted level", 32'(lvl), 32'd16);
        repeat (DEPTH) step(0, 0, 4'hF, 0, 1, 0, "drain_full");

        // Strobe masking versus unmasked instance.
        step(1, 32'hAABBCCDD, 4'b0101, 0, 0, 0, "strb");
        chk("strb masked", dat, 32'h00BB00DD);
        chk("strb unmasked", dat_nm, 32'hAABBCCDD);
        step(0, 0, 4'hF, 0, 1, 0, "strb_pop");

        // Steady level 4 with concurrent push and pop.
        for (int i = 0; i < 4; i++) step(1, $urandom, 4'hF, 1'($urandom), 0, 0, "prime4");
        for (int i = 0; i < 20; i++)
            step(1, $urandom, 4'($urandom), 1'($urandom), 1, 0, "stream4");
        chk("stream4 level", 32'(lvl), 32'd4);
        repeat (4) step(0, 0, 4'hF, 0, 1, 0, "drain4");

        // Reads while empty are ignored.
        repeat (3) step(0, 0, 4'hF, 0, 1, 0, "empty_read");

        // Flush at level 5 / two frames, coincident with a TLAST beat.
        step(1, 32'h51, 4'hF, 0, 0, 0, "pre5");
        step(1, 32'h52, 4'hF, 1, 0, 0, "pre5");
        step(1, 32'h53, 4'hF, 0, 0, 0, "pre5");
        step(1, 32'h54, 4'hF, 1, 0, 0, "pre5");
        step(1, 32'h55, 4'hF, 0, 0, 0, "pre5");
        chk("pre_flush frames", 32'(fcnt), 32'd2);
        step(1, 32'h56, 4'hF, 1, 1, 1, "flush");
        chk("flush level", 32'(lvl), 32'd0);
        step(0, 0, 4'hF, 0, 0, 0, "post_flush");

        // Random traffic.
        for (int i = 0; i < 300; i++)
            step(($urandom_range(0, 3) != 0), $urandom, 4'($urandom), ($urandom_range(0, 3) == 0),
                 ($urandom_range(0, 2) == 0), ($urandom_range(0, 40) == 0), "rand");

        // Asynchronous reset between edges in the middle of a frame.
        step(1, 32'h77, 4'hF, 0, 0, 0, "midframe");
        @(posedge clk);
        #3 rst = 1'b1;
        #1 check_zero("async_rst");
        tvalid = 0; rd = 0; fl = 0;
        q.delete();
        m_rdy = 0;
        @(negedge clk);
        rst = 1'b0;
        step(0, 0, 4'hF, 0, 0, 0, "rst_release");
        chk("release tready", 32'(tready), 32'h1);
        step(1, 32'hCAFE0001, 4'hF, 0, 0, 0, "restart");
        step(1, 32'hCAFE0002, 4'hF, 1, 0, 0, "restart");
        repeat (3) step(0, 0, 4'hF, 0, 1, 0, "restart_drain");

        $display("%0d/%0d checks passed", passes, checks);
        $finish;
    end

endmodule

// File: doc/mlp_axis_slave_fifo.md
Name: mlp_axis_slave_fifo

Overview:
- Parametrised AXI4-Stream slave input stage for the MLP accelerator. It is the successor to the single-register AXIS slave.
- Buffers incoming S_AXIS beats in a configurable-depth FIFO, applies TSTRB byte masking and preserves TLAST as a frame marker.
- Presents first-word-fall-through data to the MLP core, which pops words with pi_data_read.
- Adds level and frame-count status plus a synchronous flush, so the core can wait for a complete input vector before starting.

Parameters:
- C_S_AXIS_TDATA_WIDTH, 32, stream data width in bits; must be a multiple of 8.
- C_FIFO_DEPTH, 16, FIFO entries; must be a power of two and at least 2.
- C_STRB_MASK_EN, 1, when 1 bytes with TSTRB=0 are stored as 0x00; when 0 TSTRB is ignored.
- C_FRAME_CNT_WIDTH, 8, width of the completed-frame counter.

Ports:
- S_AXIS_ACLK  in  1  clock.
- S_AXIS_ARESET  in  1  asynchronous active-high reset.
- S_AXIS_TVALID  in  1  stream beat valid.
- S_AXIS_TREADY  out  1  stream beat accept.
- S_AXIS_TDATA  in  C_S_AXIS_TDATA_WIDTH  stream data.
- S_AXIS_TSTRB  in  C_S_AXIS_TDATA_WIDTH/8  byte strobes.
- S_AXIS_TLAST  in  1  last beat of frame.
- pi_data_read  in  1  core pops the head word.
- pi_flush  in  1  synchronous clear of FIFO and counters.
- po_mlp_data  out  C_S_AXIS_TDATA_WIDTH  head-of-FIFO word.
- po_mlp_data_valid  out  1  FIFO not empty.
- po_mlp_data_last  out  1  head word carried TLAST.
- po_fifo_level  out  clog2(C_FIFO_DEPTH)+1  occupied entries.
- po_frame_count  out  C_FRAME_CNT_WIDTH  complete frames held in the FIFO.
- po_frame_ready  out  1  po_frame_count != 0.

Behaviour:
- Reset (async assert, sync release) clears:
  - pointers, level and frame count to 0;
  - S_AXIS_TREADY, po_mlp_data_valid, po_mlp_data_last and po_frame_ready to 0;
  - po_mlp_data to 0.
- Storage: register array of C_FIFO_DEPTH x (C_S_AXIS_TDATA_WIDTH+1); the extra bit holds TLAST.
- Pointers are clog2(C_FIFO_DEPTH)+1 bits. Full and empty are decided by comparing the MSB and the index bits; the index wraps naturally at C_FIFO_DEPTH.
- S_AXIS_TREADY is registered: 1 when level < C_FIFO_DEPTH, not in reset, and not in a flush cycle. It must not depend combinationally on TVALID.
  - Registered form: next TREADY = (next_level < C_FIFO_DEPTH) && !pi_flush.
- Write occurs when TVALID && TREADY:
  - stored data = TDATA with each byte ANDed by its replicated TSTRB bit if C_STRB_MASK_EN=1;
  - stored last = TLAST.
- Read occurs when pi_data_read && po_mlp_data_valid. pi_data_read while empty is ignored, with no pointer movement and no underflow.
- Output is FWFT:
  - po_mlp_data and po_mlp_data_last are driven from mem[rd_ptr];
  - po_mlp_data_valid = (level != 0), registered;
  - a word written at edge N is visible and valid after edge N, so write-to-valid latency is 1 cycle.
- Simultaneous read and write (not full): level unchanged, both pointers advance. At full, TREADY is already 0, so no write occurs; the read frees a slot and TREADY returns 1 on the following edge.
- Frame counter:
  - +1 on a write with TLAST=1;
  - -1 on a read of a word whose stored last=1;
  - both in the same cycle: unchanged;
  - saturates at all-ones on increment and never goes below 0.
- pi_flush is synchronous and takes priority over read and write in the same cycle:
  - next edge zeroes pointers, level and frame count;
  - TREADY = 0 for that cycle;
  - a concurrent beat is not accepted.
- Reset mid-frame discards all contents. After reset TREADY rises on the first clock edge with reset low.
- Arithmetic: level and frame count are unsigned, with no wrap beyond the saturation rules above.

Decomposition:
- Package mlp_axis_pkg holds:
  - function clog2;
  - localparam-derived widths: strobe width C_S_AXIS_TDATA_WIDTH/8 and pointer width.
- One natural sub-module: mlp_sync_fifo, a generic FWFT register FIFO with level output.
- The top adds TSTRB masking, TREADY registration, TLAST tracking, frame counter and flush.

Test Plan:
- Reset, then send 3 beats 0x00000003, 0x0000000E, 0x00000019 (TLAST on third), no reads → po_fifo_level=3, po_frame_count=1, po_frame_ready=1, po_mlp_data=0x00000003 valid one cycle after the first beat.
- Fill 16 beats with pi_data_read=0 → TREADY=0 after the 16th accept and the 17th beat is held. Assert pi_data_read for one cycle → level 15, TREADY=1 next edge, the held beat is accepted.
- TDATA=0xAABBCCDD with TSTRB=4'b0101, C_STRB_MASK_EN=1 → po_mlp_data=0x00BB00DD. Rerun with C_STRB_MASK_EN=0 → 0xAABBCCDD.
- Continuous write and pi_data_read at level 4 for 20 cycles → level stays 4 and output order matches input order exactly.
- pi_data_read pulsed while empty → no change, valid=0. Then pi_flush coincident with a TLAST write at level 5, frame count 2 → next edge level=0, frame count=0, beat not accepted.
- Assert S_AXIS_ARESET asynchronously mid-frame, between clock edges → all outputs 0 immediately. After release, TREADY=1 at the first edge and the stream restarts cleanly.
